// File: rtl/calc_sequencer.sv
// Purpose : sequencing controller for the 4-bit switch calculator (debounce keys, latch A/B/op, hold result).
// Latency : key accepted 2 sync + DEBOUNCE_CYCLES cycles after it settles; ENTER in ENTER_B -> result registered 2 cycles later.
// Backpressure: none; press events that the current state does not use (ENTER during EXEC) are dropped.
//
// Ports:
//   i_clk, i_rst_n (synchronous, active-low)
//   i_key_enter_n, i_key_clear_n : raw active-low push-buttons, asynchronous to i_clk
//   i_sw_data, i_sw_op           : operand / opcode switches
//   o_alu_a, o_alu_b, o_alu_op   : registered operands and opcode to ALU and displays
//   i_alu_result                 : combinational ALU result
//   o_res_q, o_res_valid         : held result and "result belongs to current operands" flag
//   o_state                      : 0=ENTER_A, 1=ENTER_B, 2=EXEC, 3=DONE
//
// Build option: define CALC_ACCUM_EN to chain the result into operand A on an ENTER press in DONE.

module calc_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WIDTH           = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_enter_n,
    input  logic             i_key_clear_n,
    input  logic [WIDTH-1:0] i_sw_data,
    input  logic [1:0]       i_sw_op,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic [WIDTH-1:0] o_res_q,
    output logic             o_res_valid,
    output logic [1:0]       o_state
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_ENTER_A = 2'd0,
        S_ENTER_B = 2'd1,
        S_EXEC    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Key path, index 0 = ENTER, index 1 = CLEAR.
    logic [1:0]    w_key_n;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_db;
    logic [CW-1:0] r_cnt     [2];
    logic [CW-1:0] w_cnt_nxt [2];
    logic [1:0]    w_accept;
    logic [1:0]    w_press;
    logic          w_ev_enter;
    logic          w_ev_clear;

    assign w_key_n = {i_key_clear_n, i_key_enter_n};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_cnt_nxt[k] = r_cnt[k] + CW'(1);
            // The cycle the count would reach DEBOUNCE_CYCLES is the cycle the new level is taken.
            w_accept[k]  = (r_sync2[k] != r_db[k]) && (w_cnt_nxt[k] == CW'(DEBOUNCE_CYCLES));
            // Press pulse is issued alongside the debounced 1->0 update so the FSM acts on that same edge.
            w_press[k]   = w_accept[k] && r_db[k];
        end
    end

    assign w_ev_enter = w_press[0];
    assign w_ev_clear = w_press[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_db    <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_key_n;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_accept[k]) begin
                    r_db[k]  <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= w_cnt_nxt[k];
                end
            end
        end
    end

    // Sequencer FSM and datapath registers.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_alu_a,  w_alu_a_nxt;
    logic [WIDTH-1:0] r_alu_b,  w_alu_b_nxt;
    logic [1:0]       r_alu_op, w_alu_op_nxt;
    logic [WIDTH-1:0] r_res_q,  w_res_q_nxt;
    logic             r_res_valid, w_res_valid_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_ENTER_A;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_q     <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_res_q     <= w_res_q_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_op_nxt    = r_alu_op;
        w_res_q_nxt     = r_res_q;
        w_res_valid_nxt = r_res_valid;

        if (w_ev_clear) begin
            // CLEAR wins over a coincident ENTER and over the EXEC capture.
            w_state_nxt     = S_ENTER_A;
            w_alu_a_nxt     = '0;
            w_alu_b_nxt     = '0;
            w_alu_op_nxt    = '0;
            w_res_q_nxt     = '0;
            w_res_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ENTER_A: begin
                    if (w_ev_enter) begin
                        w_alu_a_nxt = i_sw_data;
                        w_state_nxt = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (w_ev_enter) begin
                        w_alu_b_nxt  = i_sw_data;
                        w_alu_op_nxt = i_sw_op;
                        w_state_nxt  = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable since the previous edge; ENTER here is dropped.
                    w_res_q_nxt     = i_alu_result;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end
                S_DONE: begin
                    if (w_ev_enter) begin
                        w_res_valid_nxt = 1'b0;
`ifdef CALC_ACCUM_EN
                        w_alu_a_nxt = r_res_q;
                        w_state_nxt = S_ENTER_B;
`else
                        w_state_nxt = S_ENTER_A;
`endif
                    end
                end
                default: w_state_nxt = S_ENTER_A;
            endcase
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_res_q     = r_res_q;
    assign o_res_valid = r_res_valid;
    assign o_state     = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Purpose : self-checking bench for calc_sequencer with DEBOUNCE_CYCLES=4 and a behavioural ALU.
// Latency : a key driven low at cycle c produces the FSM update at cycle c+6 (2 sync + 4 debounce).
// Backpressure: n/a; expected snapshots are queued with a due cycle and compared by a separate monitor.

module tb_calc_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_enter_n;
    logic         key_clear_n;
    logic [W-1:0] sw_data;
    logic [1:0]   sw_op;
    logic [W-1:0] alu_a, alu_b, alu_result, res_q;
    logic [1:0]   alu_op, state;
    logic         res_valid;

    calc_sequencer #(.DEBOUNCE_CYCLES(4), .WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_key_enter_n (key_enter_n),
        .i_key_clear_n (key_clear_n),
        .i_sw_data     (sw_data),
        .i_sw_op       (sw_op),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_op      (alu_op),
        .i_alu_result  (alu_result),
        .o_res_q       (res_q),
        .o_res_valid   (res_valid),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    // Environment ALU: op0 a+b, op1 a-b, op2 a&b, op3 a|b, all mod 16.
    always_comb begin
        case (alu_op)
            2'd0:    alu_result = alu_a + alu_b;
            2'd1:    alu_result = alu_a - alu_b;
            2'd2:    alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] res;
        logic         vld;
        logic [1:0]   st;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    stim_done = 1'b0;

    task automatic expect_at(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] op, input logic [W-1:0] res, input logic vld,
                             input logic [1:0] st, input string name);
        exp_t e;
        e.due = cyc + d; e.a = a; e.b = b; e.op = op; e.res = res; e.vld = vld; e.st = st;
        sb.push_back(e);
        sb_name.push_back(name);
    endtask

    // Monitor: pops every snapshot that has fallen due and compares against the DUT outputs.
    exp_t  m_e;
    string m_n;
    always @(negedge clk) begin
        while (sb.size() > 0 && (sb[0].due <= cyc || stim_done)) begin
            m_e = sb.pop_front();
            m_n = sb_name.pop_front();
            n_checks++;
            if (m_e.due != cyc) begin
                n_fail++;
                $display("FAIL %s: snapshot due at cycle %0d not compared (now %0d)", m_n, m_e.due, cyc);
            end else if ({alu_a, alu_b, alu_op, res_q, res_valid, state} !==
                         {m_e.a, m_e.b, m_e.op, m_e.res, m_e.vld, m_e.st}) begin
                n_fail++;
                $display("FAIL %s @%0d: got a=%0d b=%0d op=%0d res=%0d vld=%0d st=%0d, want a=%0d b=%0d op=%0d res=%0d vld=%0d st=%0d",
                         m_n, cyc, alu_a, alu_b, alu_op, res_q, res_valid, state,
                         m_e.a, m_e.b, m_e.op, m_e.res, m_e.vld, m_e.st);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the selected keys low for 'hold' cycles, release, then let the release debounce out.
    task automatic press(input bit ent, input bit clr, input int hold);
        key_enter_n = ~ent;
        key_clear_n = ~clr;
        wait_n(hold);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        wait_n(12);
    endtask

    initial begin
        rst_n       = 1'b0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        sw_data     = '0;
        sw_op       = '0;
        wait_n(2);

        // Reset state, and no spurious press after release.
        expect_at(1, 0, 0, 0, 0, 0, 0, "reset");
        expect_at(8, 0, 0, 0, 0, 0, 0, "reset_no_event");
        rst_n = 1'b1;
        wait_n(10);

        // Bounce: 3 low cycles never reach 4 stable debounced cycles.
        sw_data = 4'd3;
        expect_at(6, 0, 0, 0, 0, 0, 0, "bounce_short");
        expect_at(14, 0, 0, 0, 0, 0, 0, "bounce_short_late");
        press(1, 0, 3);

        // Long press with sw_data=3: exactly one event.
        expect_at(5, 0, 0, 0, 0, 0, 0, "enter_a_before");
        expect_at(6, 3, 0, 0, 0, 0, 1, "enter_a");
        expect_at(21, 3, 0, 0, 0, 0, 1, "enter_a_single_event");
        press(1, 0, 10);

        // Switches moving while waiting must not disturb latched values.
        sw_data = 4'd9; sw_op = 2'd3;
        expect_at(3, 3, 0, 0, 0, 0, 1, "sw_change_hold");
        wait_n(5);

        // Operand B, EXEC for one cycle, result two cycles after the event.
        sw_data = 4'd5; sw_op = 2'd0;
        expect_at(5, 3, 0, 0, 0, 0, 1, "enter_b_before");
        expect_at(6, 3, 5, 0, 0, 0, 2, "exec");
        expect_at(7, 3, 5, 0, 8, 1, 3, "done_3p5");
        expect_at(18, 3, 5, 0, 8, 1, 3, "done_hold");
        press(1, 0, 8);

        // ENTER in DONE.
        sw_data = 4'd15;
`ifdef CALC_ACCUM_EN
        expect_at(6, 8, 5, 0, 8, 0, 1, "done_press_accum");
`else
        expect_at(6, 3, 5, 0, 8, 0, 0, "done_press");
`endif
        press(1, 0, 8);

        // CLEAR returns everything to zero.
        expect_at(6, 0, 0, 0, 0, 0, 0, "clear");
        press(0, 1, 8);

        // Wrap-around subtraction 2-5 = 13.
        sw_data = 4'd2;
        expect_at(6, 2, 0, 0, 0, 0, 1, "wrap_a");
        press(1, 0, 8);
        sw_data = 4'd5; sw_op = 2'd1;
        expect_at(6, 2, 5, 1, 0, 0, 2, "wrap_exec");
        expect_at(7, 2, 5, 1, 13, 1, 3, "wrap_result");
        press(1, 0, 8);

        // Clear from DONE, then A=7, then ENTER and CLEAR on the same cycle.
        expect_at(6, 0, 0, 0, 0, 0, 0, "clear_from_done");
        press(0, 1, 8);
        sw_data = 4'd7; sw_op = 2'd0;
        expect_at(6, 7, 0, 0, 0, 0, 1, "prio_a");
        press(1, 0, 8);
        sw_data = 4'd4;
        expect_at(6, 0, 0, 0, 0, 0, 0, "clear_priority");
        expect_at(16, 0, 0, 0, 0, 0, 0, "clear_priority_late");
        press(1, 1, 8);

        wait_n(4);
        stim_done = 1'b1;
        wait_n(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Sequencing controller for the 4-bit switch calculator. It sits between the board inputs (switches, push-buttons) and the 4-bit ALU.
- Debounces the ENTER and CLEAR keys.
- Latches operand A, operand B and the opcode in sequence, and drives them to the ALU.
- Latches the ALU result into a held register for the result display.
- Replaces direct switch-to-ALU wiring, so all three displays show stable registered values.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles after synchronization before a key level is accepted (20 ms at 50 MHz). Minimum 1; simulation uses 4.
- WIDTH, 4: operand and result width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- key_enter_n  in  1  ENTER push-button, active-low, asynchronous to clk
- key_clear_n  in  1  CLEAR push-button, active-low, asynchronous to clk
- sw_data  in  WIDTH  operand switches
- sw_op  in  2  opcode switches
- alu_a  out  WIDTH  registered operand A to ALU / display
- alu_b  out  WIDTH  registered operand B to ALU / display
- alu_op  out  2  registered opcode to ALU
- alu_result  in  WIDTH  combinational ALU result
- res_q  out  WIDTH  latched result for display
- res_valid  out  1  res_q holds a result of the current operand set
- state_o  out  2  0=ENTER_A, 1=ENTER_B, 2=EXEC, 3=DONE

Behaviour:
- Reset (rst_n low at a clk edge): state ENTER_A. alu_a, alu_b, alu_op, res_q = 0; res_valid = 0. Synchronizer flops = 1, debounced levels = 1 (released), debounce counters = 0. Reset overrides every other event, including mid-EXEC.
- Key path, per key, independent:
  - 2-flop synchronizer.
  - Counter increments while the synchronized level differs from the debounced level and clears when they are equal. When it reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - Press event = single-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- FSM, evaluated on press events (ev_enter, ev_clear):
  - ENTER_A: ev_enter -> alu_a <= sw_data; go to ENTER_B.
  - ENTER_B: ev_enter -> alu_b <= sw_data, alu_op <= sw_op; go to EXEC.
  - EXEC: lasts exactly one cycle, with ALU inputs stable since the previous edge. At the end of the cycle, res_q <= alu_result and res_valid <= 1; go to DONE. ev_enter arriving during EXEC is dropped.
  - DONE: ev_enter -> res_valid <= 0; next state per the optional feature.
  - Any state: ev_clear -> alu_a, alu_b, alu_op, res_q = 0; res_valid = 0; go to ENTER_A. CLEAR takes priority over ENTER in the same cycle.
- Latency: the ev_enter pulse in ENTER_B at cycle N gives state EXEC at N+1 and res_q/res_valid updated at N+2.
- Switch changes while waiting never alter the latched registers.
- Width: res_q takes alu_result verbatim (mod 2^WIDTH). No carry or overflow is stored.
- Outputs hold their value in every state not listed as updating them.

Optional Feature:
CALC_ACCUM_EN
- Defined: ev_enter in DONE sets alu_a <= res_q and goes to ENTER_B, so results chain as operand A of the next operation.
- Undefined: ev_enter in DONE goes to ENTER_A with alu_a unchanged until the next ENTER_A press.
- CLEAR behaviour is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4; ALU model: op0=a+b, op1=a-b, mod 16):
- Reset: hold rst_n low 2 cycles with keys released -> all outputs 0, state_o=0, no press event after release.
- Bounce: key_enter_n low for 3 cycles then high -> no event, state_o stays 0. Low for 10 cycles -> exactly one event, state_o=1.
- Full operation:
  - Press with sw_data=3 -> alu_a=3.
  - Press with sw_data=5, sw_op=0 -> alu_b=5, state EXEC for 1 cycle.
  - 2 cycles after the event: res_q=8, res_valid=1, state_o=3.
- Wrap-around: a=2, b=5, op=1 -> res_q=13 (0xD), res_valid=1.
- Clear priority: in ENTER_B with alu_a=7, align ENTER and CLEAR events in the same cycle -> alu_a=0, alu_b=0, state_o=0, res_valid=0.
- DONE press after res_q=8:
  - With CALC_ACCUM_EN: alu_a=8, state_o=1, res_valid=0.
  - Without: state_o=0, alu_a unchanged, res_valid=0.
